// File: rtl/memory_ctrl_pkg.sv
// Shared types and default widths for the system/memory command responder.
package memory_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_MEM_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        READ_WAIT = 3'd3,
        DONE      = 3'd4
    } mctrl_state_t;

endpackage

// File: rtl/memory_ctrl.sv
// Responder for single read/write commands: strobes the memory core and returns
// read data on the shared data_sys bus with a one-cycle ready_sys completion pulse.
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_sys,
    input  logic              we_sys,
    input  logic [ADDR_W-1:0] addr_sys,
    inout  wire  [DATA_W-1:0] data_sys,
    output logic              ready_sys,
    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem
);

    localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    mctrl_state_t      r_state;
    mctrl_state_t      w_next_state;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_drive_en;
    logic              r_ready;
    logic              r_ce;
    logic              r_we_mem;
    logic [ADDR_W-1:0] r_addr_mem;
    logic [DATA_W-1:0] r_datai;
    logic              w_accept;
    logic              w_cnt_last;

    assign w_accept   = (r_state == IDLE) && cmd_valid_sys;
    // Treating 0 as "last" as well keeps READ_WAIT from ever stalling.
    assign w_cnt_last = (r_cnt <= CNT_W'(1));

    // Next-state decode; commands outside IDLE are dropped, not queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid_sys) begin
                    w_next_state = we_sys ? WRITE : READ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WRITE:     w_next_state = DONE;
            READ:      w_next_state = READ_WAIT;
            READ_WAIT: begin
                if (w_cnt_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = READ_WAIT;
                end
            end
            DONE:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // State register, command capture and registered memory/system strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_ready    <= 1'b0;
            r_ce       <= 1'b0;
            r_we_mem   <= 1'b0;
            r_drive_en <= 1'b0;
            r_addr_mem <= {ADDR_W{1'b0}};
            r_datai    <= {DATA_W{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_ready    <= (w_next_state == DONE);
            r_ce       <= (w_next_state == WRITE) || (w_next_state == READ);
            r_we_mem   <= (w_next_state == WRITE);
            r_drive_en <= (w_next_state == DONE) && !r_we;
            if (w_accept) begin
                r_we       <= we_sys;
                r_addr_mem <= addr_sys;
                if (we_sys) begin
                    r_datai <= data_sys;
                end
            end
        end
    end

    // Read latency counter and capture of returned memory data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_rdata <= {DATA_W{1'b0}};
        end else if (r_state == READ) begin
            r_cnt <= CNT_W'(MEM_LATENCY);
        end else if (r_state == READ_WAIT) begin
            if (r_cnt != {CNT_W{1'b0}}) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_cnt_last) begin
                r_rdata <= datao_mem;
            end
        end
    end

    assign ready_sys = r_ready;
    assign ce_mem    = r_ce;
    assign we_mem    = r_we_mem;
    assign addr_mem  = r_addr_mem;
    assign datai_mem = r_datai;
    assign data_sys  = r_drive_en ? r_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench: one controller with MEM_LATENCY=1 (index 0), one with 3 (index 1).
module tb_memory_ctrl;
    import memory_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] cmd_valid;
    logic [1:0] we;
    logic [7:0] addr [2];
    logic [7:0] drv_data [2];
    logic [1:0] drv_en;
    wire  [7:0] dsys0;
    wire  [7:0] dsys1;
    logic [1:0] ready;
    logic [1:0] ce;
    logic [1:0] wem;
    logic [7:0] addr_mem [2];
    logic [7:0] datai [2];
    logic [7:0] datao [2];

    logic [7:0]       mem [2][256];
    logic [2:0]       pv [2];
    logic [2:0][7:0]  pa [2];
    int               ce_cnt [2];
    int               rdy_cnt [2];
    int               checks;
    int               errors;
    int               ce_base;
    int               rdy_base;

    assign dsys0 = drv_en[0] ? drv_data[0] : 8'hzz;
    assign dsys1 = drv_en[1] ? drv_data[1] : 8'hzz;

    memory_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid_sys(cmd_valid[0]), .we_sys(we[0]),
        .addr_sys(addr[0]), .data_sys(dsys0), .ready_sys(ready[0]), .ce_mem(ce[0]),
        .we_mem(wem[0]), .addr_mem(addr_mem[0]), .datai_mem(datai[0]), .datao_mem(datao[0])
    );

    memory_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(3)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid_sys(cmd_valid[1]), .we_sys(we[1]),
        .addr_sys(addr[1]), .data_sys(dsys1), .ready_sys(ready[1]), .ce_mem(ce[1]),
        .we_mem(wem[1]), .addr_mem(addr_mem[1]), .datai_mem(datai[1]), .datao_mem(datao[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data valid exactly MEM_LATENCY cycles after the strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ce[d] && wem[d]) mem[d][addr_mem[d]] <= datai[d];
            pv[d] <= {pv[d][1:0], ce[d] && !wem[d]};
            pa[d] <= {pa[d][1], pa[d][0], addr_mem[d]};
            if (ce[d]) ce_cnt[d] <= ce_cnt[d] + 1;
            if (ready[d]) rdy_cnt[d] <= rdy_cnt[d] + 1;
        end
    end

    always_comb begin
        datao[0] = pv[0][0] ? mem[0][pa[0][0]] : 8'hEE;
        datao[1] = pv[1][2] ? mem[1][pa[1][2]] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present a command at a negedge, let edge N take it, return in cycle N+1.
    task automatic issue(input int d, input logic w, input logic [7:0] a, input logic [7:0] dat);
        cmd_valid[d] = 1'b1;
        we[d]        = w;
        addr[d]      = a;
        drv_data[d]  = dat;
        drv_en[d]    = w;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        drv_en[d]    = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; cmd_valid = 2'b00; we = 2'b00; drv_en = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 8'h00; drv_data[d] = 8'h00; pv[d] = 3'b000; pa[d] = '0;
            ce_cnt[d] = 0; rdy_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        cyc();
        chk("rst_ready0", {7'd0, ready[0]}, 8'h00);
        chk("rst_ce1", {7'd0, ce[1]}, 8'h00);
        chk("rst_addr0", addr_mem[0], 8'h00);
        chk("rst_datai1", datai[1], 8'h00);
        chk("rst_state0", 8'(dut0.r_state), 8'(IDLE));
        chk("rst_drive0", {7'd0, dut0.r_drive_en}, 8'h00);
        reset = 1'b0;
        cyc();

        // Write 3C=A5 on the latency-1 controller.
        issue(0, 1'b1, 8'h3C, 8'hA5);
        chk("wr_ce", {7'd0, ce[0]}, 8'h01);
        chk("wr_we", {7'd0, wem[0]}, 8'h01);
        chk("wr_addr", addr_mem[0], 8'h3C);
        chk("wr_datai", datai[0], 8'hA5);
        chk("wr_ready_early", {7'd0, ready[0]}, 8'h00);
        cyc();
        chk("wr_ready", {7'd0, ready[0]}, 8'h01);
        chk("wr_ce_off", {7'd0, ce[0]}, 8'h00);
        chk("wr_drive_off", {7'd0, dut0.r_drive_en}, 8'h00);
        cyc();
        chk("wr_ready_pulse", {7'd0, ready[0]}, 8'h00);
        issue(0, 1'b1, 8'h3C, 8'h5A);
        cyc(); cyc();

        // Read 3C with MEM_LATENCY=1.
        issue(0, 1'b0, 8'h3C, 8'h00);
        chk("rd1_ce", {7'd0, ce[0]}, 8'h01);
        chk("rd1_we", {7'd0, wem[0]}, 8'h00);
        chk("rd1_addr", addr_mem[0], 8'h3C);
        cyc();
        chk("rd1_ready_early", {7'd0, ready[0]}, 8'h00);
        chk("rd1_ce_off", {7'd0, ce[0]}, 8'h00);
        cyc();
        chk("rd1_ready", {7'd0, ready[0]}, 8'h01);
        chk("rd1_data", dsys0, 8'h5A);
        cyc();
        chk("rd1_ready_pulse", {7'd0, ready[0]}, 8'h00);
        chk("rd1_release", {7'd0, dut0.r_drive_en}, 8'h00);

        // MEM_LATENCY=3 read with a busy command pulsed during READ_WAIT.
        issue(1, 1'b1, 8'h3C, 8'h5A);
        cyc(); cyc();
        ce_base = ce_cnt[1]; rdy_base = rdy_cnt[1];
        issue(1, 1'b0, 8'h3C, 8'h00);
        chk("rd3_ce", {7'd0, ce[1]}, 8'h01);
        chk("rd3_we", {7'd0, wem[1]}, 8'h00);
        cyc();
        cmd_valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h10;
        cyc();
        cmd_valid[1] = 1'b0;
        chk("rd3_ready_n3", {7'd0, ready[1]}, 8'h00);
        cyc();
        chk("rd3_ready_n4", {7'd0, ready[1]}, 8'h00);
        cyc();
        chk("rd3_ready", {7'd0, ready[1]}, 8'h01);
        chk("rd3_data", dsys1, 8'h5A);
        chk("busy_addr", addr_mem[1], 8'h3C);
        cyc();
        chk("rd3_ready_pulse", {7'd0, ready[1]}, 8'h00);
        cyc(); cyc(); cyc();
        chk("busy_ce_count", 8'(ce_cnt[1] - ce_base), 8'h01);
        chk("busy_rdy_count", 8'(rdy_cnt[1] - rdy_base), 8'h01);

        // Back-to-back: write FF, read FF next cycle after ready, then write immediately.
        issue(0, 1'b1, 8'hFF, 8'hC3);
        cyc();
        chk("b2b_wr_ready", {7'd0, ready[0]}, 8'h01);
        cyc();
        issue(0, 1'b0, 8'hFF, 8'h00);
        chk("b2b_rd_addr", addr_mem[0], 8'hFF);
        cyc(); cyc();
        chk("b2b_rd_ready", {7'd0, ready[0]}, 8'h01);
        chk("b2b_rd_data", dsys0, 8'hC3);
        cyc();
        drv_en[0] = 1'b1; drv_data[0] = 8'h77;
        #1;
        chk("turn_bus", dsys0, 8'h77);
        chk("turn_drive_off", {7'd0, dut0.r_drive_en}, 8'h00);
        issue(0, 1'b1, 8'h20, 8'h77);
        chk("turn_wr_datai", datai[0], 8'h77);
        chk("turn_wr_ce", {7'd0, ce[0]}, 8'h01);
        cyc();

        // Reset during a MEM_LATENCY=3 read; a command held during reset must be dropped.
        rdy_base = rdy_cnt[1];
        issue(1, 1'b0, 8'h3C, 8'h00);
        chk("rstmid_ce", {7'd0, ce[1]}, 8'h01);
        cyc();
        reset = 1'b1;
        cmd_valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rstmid_ready", {7'd0, ready[1]}, 8'h00);
            chk("rstmid_ce_off", {7'd0, ce[1]}, 8'h00);
            chk("rstmid_state", 8'(dut1.r_state), 8'(IDLE));
            chk("rstmid_drive", {7'd0, dut1.r_drive_en}, 8'h00);
        end
        chk("rstmid_addr", addr_mem[1], 8'h00);
        reset = 1'b0;
        cmd_valid[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rstmid_no_ready", {7'd0, ready[1]}, 8'h00);
        end
        chk("rstmid_rdy_count", 8'(rdy_cnt[1] - rdy_base), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
